// File: rtl/uart_rx_if.sv
// Bus-side and line-side signals of the UART receiver.
// The receiver uses the slave modport; the line driver and the consumer use master.
`timescale 1ns/1ps
interface uart_rx_if #(
    parameter int Nbit = 8
);
    logic            SerialDataIn;
    logic            clr_rx_flag;
    logic [Nbit-1:0] DataRx;
    logic            endRx_flag;
    logic            frame_err;
    logic            overrun;

    modport slave (
        input  SerialDataIn,
        input  clr_rx_flag,
        output DataRx,
        output endRx_flag,
        output frame_err,
        output overrun
    );

    modport master (
        output SerialDataIn,
        output clr_rx_flag,
        input  DataRx,
        input  endRx_flag,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, sticky completion flag,
// framing and overrun detection. Baud timing matches uart_tx.
`timescale 1ns/1ps
module uart_rx #(
    parameter int Nbit     = 8,
    parameter int baudrate = 9600,
    parameter int clk_freq = 50000000
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int BIT_TIME = clk_freq / baudrate;
    localparam int HALF_BIT = BIT_TIME / 2;
    localparam int BAUD_W   = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
    localparam int BITN_W   = $clog2(Nbit) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_TIME - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(HALF_BIT - 1);
    localparam logic [BITN_W-1:0] BIT_LAST  = BITN_W'(Nbit - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [1:0]        sync_q, sync_d;
    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BITN_W-1:0] bitn_q, bitn_d;
    logic [Nbit-1:0]   shift_q, shift_d;
    logic [Nbit-1:0]   data_q, data_d;
    logic              end_q, end_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              rx_s;
    logic              done;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], bus.SerialDataIn};
        state_d = state_q;
        baud_d  = baud_q;
        bitn_d  = bitn_q;
        shift_d = shift_q;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bitn_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (baud_q == BAUD_HALF) begin
                    baud_d  = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[Nbit-1:1]};
                    if (bitn_q == BIT_LAST) begin
                        bitn_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        bitn_d = bitn_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    done    = 1'b1;
                    state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            // A held-low line (break) must not be mistaken for the next start bit.
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        end_d  = end_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (!bus.clr_rx_flag) begin
            end_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        // Completion overrides a simultaneous clear; overrun then reads 0.
        if (done) begin
            data_d = shift_q;
            end_d  = 1'b1;
            ferr_d = ~rx_s;
            ovr_d  = bus.clr_rx_flag ? (ovr_q | end_q) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            baud_q  <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            end_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            end_q   <= end_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.DataRx     = data_q;
    assign bus.endRx_flag = end_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART TX line: it captures an asynchronous 8N1-style frame from the serial input, samples each bit at its midpoint, and presents the assembled word with a completion flag to the bus-side logic. Its baud timing matches UART_TX exactly, so a TX/RX pair at the same parameters forms a loopback path. Framing and overrun conditions are flagged, and the flags are cleared by the consumer.

## Interface
- Nbit, 8, data bits per frame, LSB first.
- baudrate, 9600, line rate in bit/s.
- clk_freq, 50000000, system clock in Hz.
- bit_time, clk_freq/baudrate, clocks per bit; must be ≥ 4.
- half_bit, bit_time/2, clocks from start-edge detection to the start-bit midpoint.
- baud_cnt_bits, CeilLog2(bit_time), baud counter width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- SerialDataIn  in  1  serial line, idle high, asynchronous to clk.
- clr_rx_flag  in  1  active-low; while 0, clears endRx_flag, frame_err and overrun.
- DataRx  out  Nbit  last received word.
- endRx_flag  out  1  set when a frame completes; sticky until cleared.
- frame_err  out  1  set when the last frame's stop bit sampled 0.
- overrun  out  1  set when a frame completes while endRx_flag is already 1.

## Operation
- SerialDataIn passes through a 2-flop synchronizer; both flops reset to 1. The FSM sees only the synchronized value, rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: baud_count=0, bit_number=0. If rx_s==0, go to START.
- START: baud_count increments each cycle. At baud_count==half_bit-1:
  - if rx_s==0: baud_count←0 and go to DATA.
  - else: glitch; return to IDLE with no flag change.
- DATA: baud_count increments each cycle. At baud_count==bit_time-1:
  - shift register ← {rx_s, shift[Nbit-1:1]}, so the LSB arrives first.
  - bit_number+1; baud_count←0.
  - after the Nbit-th sample, go to STOP.
- STOP: at baud_count==bit_time-1, sample rx_s and do all of the following:
  - DataRx←shift register, whether or not the stop bit is good.
  - endRx_flag←1.
  - frame_err←~rx_s.
  - overrun←1 if endRx_flag was already 1; otherwise overrun is unchanged.
  - next state: IDLE if rx_s==1, else WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as a new start bit.
- clr_rx_flag==0 clears all three flags. It does not stall the FSM or change DataRx.
- Simultaneous clear and frame completion in the same cycle: the completion wins. endRx_flag=1, frame_err reflects the new frame, and overrun is 0.
- Arithmetic: baud_count is baud_cnt_bits wide and never exceeds bit_time-1. bit_number is CeilLog2(Nbit)+1 bits wide.

## Timing
- Reset values: DataRx=0, endRx_flag=0, frame_err=0, overrun=0, FSM=IDLE, synchronizer=11.
- Reset asserted mid-frame aborts the frame immediately; no flag is set.
- Line falling edge to IDLE exit: 2–3 clk (synchronizer plus one FSM cycle).
- The start-bit check falls half_bit cycles after START entry.
- Each data bit is sampled bit_time cycles after the previous sample, so samples land at the bit centres ± 1 clk.
- endRx_flag rises one clk after the stop-bit sample cycle. DataRx is valid in the same cycle as the flag.
- Back-to-back frames are supported: IDLE is re-entered before the next start edge, which leaves about half a bit of margin.

## Test plan
Test parameters: clk_freq=16, baudrate=1, bit_time=16, half_bit=8.

- **Reset:** hold reset=0 with the line toggling → all outputs stay 0 and the FSM stays in IDLE. Release reset → the first frame is received correctly.
- **Nominal frame:** send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop=1) → DataRx=0xA5, endRx_flag=1, frame_err=0, overrun=0. Drive clr_rx_flag=0 for one cycle → endRx_flag=0 and DataRx holds 0xA5.
- **Glitch rejection:** pulse the line low for 4 clk → FSM returns to IDLE, no flag is set, and DataRx is unchanged.
- **Framing error:** send 0x3C with stop=0, holding the line low for 40 clk → DataRx=0x3C, endRx_flag=1, frame_err=1. No new frame starts until the line goes high; a following 0x81 is then received with frame_err=0.
- **Overrun and priority:** send 0x11 then 0x22 back-to-back without clearing → DataRx=0x22, overrun=1. Repeat with clr_rx_flag=0 asserted in the exact completion cycle of 0x22 → endRx_flag=1, overrun=0.
- **Loopback:** connect UART_TX with the same parameters to SerialDataIn and send 0x00, 0xFF, 0x55 → each is received exactly, with no frame_err.
